sr_flag_bank: RTL and testbench
===============================

# sr_flag_bank

Clocked, parametrised bank of CH independent set/reset flag cells. It replaces free-running cross-coupled NOR latches in synchronous designs. Each channel takes set/reset requests, optionally synchronises and edge-qualifies them, and resolves the both-asserted case by a parameter-selected policy instead of leaving it undefined. It also reports conflicts through sticky per-channel flags and a saturating counter, for status/interrupt logic.

## Interface
- CH, 8: number of flag channels (1..32).
- MODE, 0: both-asserted policy. 0 = reset-dominant, 1 = set-dominant, 2 = toggle, 3 = hold.
- SYNC_STAGES, 0: synchroniser flops on set/reset inputs (0, 2 or 3).
- EDGE, 0: 0 = level-sensitive requests; 1 = act only on rising edge of each request.
- CNT_W, 8: conflict counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set  in  CH  per-channel set request.
- reset  in  CH  per-channel reset request.
- clr  in  1  synchronous clear of conflict status.
- q  out  CH  flag state.
- qbar  out  CH  always exactly ~q (never both 0).
- chg  out  CH  one-cycle pulse when q[i] changes.
- conflict  out  CH  sticky: channel saw set and reset together.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

## Operation
- Request path per channel: synchroniser (SYNC_STAGES flops, bypassed if 0) gives s_q/r_q.
  - EDGE=1: effective s_e = s_q & ~s_prev, and r_e likewise; prev registers track s_q/r_q.
  - EDGE=0: s_e = s_q, r_e = r_q.
- Next state per channel:
  - s_e=0, r_e=0: hold.
  - s_e=1, r_e=0: q=1.
  - s_e=0, r_e=1: q=0.
  - s_e=1, r_e=1: MODE 0 → 0; MODE 1 → 1; MODE 2 → ~q; MODE 3 → hold.
- chg[i] = 1 for one cycle after any edge where q[i] changed. It is registered and aligned with the new q.
- Conflict: s_e[i]&r_e[i] sets conflict[i]. conflict_cnt increments by 1 per cycle in which any channel conflicts, regardless of how many; it saturates at 2^CNT_W-1 and never wraps.
- clr: clears conflict and conflict_cnt. If a conflict occurs in the same cycle, that event is kept: conflict bits for conflicting channels load 1 and the counter loads 1.
- Conflicts are flagged under every MODE, including hold.
- Edge-mode conflict means both rising edges land in the same cycle.

## Timing
- Reset (rst_n low, async, immediate):
  - q=0, qbar=all 1, chg=0, conflict=0, conflict_cnt=0.
  - Synchroniser and prev registers are 0.
  - Outputs hold these values while rst_n is low.
- Deassertion is synchronous to clk in the system. The first active edge after deassertion processes inputs normally.
- A request held high across reset deassertion is seen as a rising edge in EDGE=1, because prev is 0.
- Latency, input sampled at edge k → q updated at edge k+SYNC_STAGES. With SYNC_STAGES=0, q is visible after the same edge that samples it.
- Reset mid-operation discards in-flight synchroniser contents; there is no replay.
- No combinational path from inputs to outputs.

## Structure
- Package sr_flag_pkg holds:
  - MODE encodings MODE_RST_DOM=0, MODE_SET_DOM=1, MODE_TOGGLE=2, MODE_HOLD=3.
  - Function resolve(mode, s, r, q) returning next q.
- Sub-module sr_flag_cell contains synchroniser, edge detect, resolve, q/qbar/chg registers and conflict output for one channel. It is generated CH times.
- The top level owns the OR-reduce of per-channel conflict events, the sticky register and the saturating counter.

## Test plan
- Reset then basic: CH=8, MODE=0, SYNC=0; set=8'h05 for 1 cycle → q=8'h05, qbar=8'hFA, chg=8'h05 for one cycle; then reset=8'h01 → q=8'h04.
- Both-asserted, all modes: q[0]=1, set=reset=1 for 1 cycle → q[0] is 0/1/0/1 for MODE 0/1/2/3. Toggle held 3 cycles gives 0,1,0. conflict[0]=1 and conflict_cnt=1 after one cycle in each mode.
- Saturation/clr: CNT_W=3, conflict every cycle on channels 0 and 1 for 10 cycles → cnt increments once per cycle and stops at 7. clr alone → cnt=0, conflict=0. clr coincident with a conflict → cnt=1.
- Edge mode: EDGE=1, set[2] held high 5 cycles with reset[2] pulsed in cycle 2 → q[2]=1, then 0, and stays 0. The held set does not re-set it.
- Latency: SYNC_STAGES=2, set[3] rises before edge k → q[3] goes high after edge k+2, and chg[3] pulses in the same cycle.
- Async reset mid-operation: q=8'hFF, rst_n dropped between edges → q=0, qbar=FF, cnt=0 immediately. Pending synchronised requests are lost after release.

Source files
------------

// File: rtl/sr_flag_pkg.sv
// Shared definitions for the set/reset flag bank: both-asserted policy
// encodings and the per-channel next-state resolver.
package sr_flag_pkg;

    localparam logic [1:0] MODE_RST_DOM = 2'd0;
    localparam logic [1:0] MODE_SET_DOM = 2'd1;
    localparam logic [1:0] MODE_TOGGLE  = 2'd2;
    localparam logic [1:0] MODE_HOLD    = 2'd3;

    // Next flag value from effective set/reset requests and current state.
    function automatic logic resolve(input logic [1:0] mode,
                                     input logic       s,
                                     input logic       r,
                                     input logic       q);
        logic nq;
        nq = q;
        case ({s, r})
            2'b10:   nq = 1'b1;
            2'b01:   nq = 1'b0;
            2'b11: begin
                case (mode)
                    MODE_RST_DOM: nq = 1'b0;
                    MODE_SET_DOM: nq = 1'b1;
                    MODE_TOGGLE:  nq = ~q;
                    default:      nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// One flag channel: optional synchroniser, optional rising-edge qualifier,
// policy resolution and registered q/qbar/chg. The conflict event is left
// unregistered so the bank can fold it into its sticky status the same cycle.
module sr_flag_cell
    import sr_flag_pkg::*;
#(
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 0,
    parameter int EDGE        = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_i,
    input  logic reset_i,
    output logic q_o,
    output logic qbar_o,
    output logic chg_o,
    output logic conflict_o
);

    localparam logic [1:0] MODE_SEL = 2'(MODE);

    logic s_sync, r_sync;
    logic s_e, r_e;
    logic q_d, q_q, chg_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_sync = set_i;
            assign r_sync = reset_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] s_sync_q, r_sync_q;
            // Shift raw requests through the synchroniser chain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_sync_q <= '0;
                    r_sync_q <= '0;
                end else begin
                    s_sync_q[0] <= set_i;
                    r_sync_q[0] <= reset_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        s_sync_q[k] <= s_sync_q[k-1];
                        r_sync_q[k] <= r_sync_q[k-1];
                    end
                end
            end
            assign s_sync = s_sync_q[SYNC_STAGES-1];
            assign r_sync = r_sync_q[SYNC_STAGES-1];
        end

        if (EDGE != 0) begin : g_edge
            logic s_prev_q, r_prev_q;
            // Remember last synchronised level; prev starts at 0 so a request
            // held across reset release counts as a rising edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_prev_q <= 1'b0;
                    r_prev_q <= 1'b0;
                end else begin
                    s_prev_q <= s_sync;
                    r_prev_q <= r_sync;
                end
            end
            assign s_e = s_sync & ~s_prev_q;
            assign r_e = r_sync & ~r_prev_q;
        end else begin : g_level
            assign s_e = s_sync;
            assign r_e = r_sync;
        end
    endgenerate

    assign q_d = resolve(MODE_SEL, s_e, r_e, q_q);

    // Flag state and its change pulse, both aligned to the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= q_d ^ q_q;
        end
    end

    assign q_o        = q_q;
    assign qbar_o     = ~q_q;
    assign chg_o      = chg_q;
    assign conflict_o = s_e & r_e;

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of CH clocked set/reset flags with sticky per-channel conflict status
// and a saturating count of cycles in which any channel conflicted.
module sr_flag_bank
    import sr_flag_pkg::*;
#(
    parameter int CH          = 8,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 0,
    parameter int EDGE        = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    set,
    input  logic [CH-1:0]    reset,
    input  logic             clr,
    output logic [CH-1:0]    q,
    output logic [CH-1:0]    qbar,
    output logic [CH-1:0]    chg,
    output logic [CH-1:0]    conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CH-1:0]    ev;
    logic [CH-1:0]    conflict_d, conflict_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             any_ev;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_cell
            sr_flag_cell #(
                .MODE        (MODE),
                .SYNC_STAGES (SYNC_STAGES),
                .EDGE        (EDGE)
            ) u_cell (
                .clk        (clk),
                .rst_n      (rst_n),
                .set_i      (set[i]),
                .reset_i    (reset[i]),
                .q_o        (q[i]),
                .qbar_o     (qbar[i]),
                .chg_o      (chg[i]),
                .conflict_o (ev[i])
            );
        end
    endgenerate

    assign any_ev = |ev;

    // Sticky status and saturating count; a conflict coinciding with clr survives.
    always_comb begin
        conflict_d = conflict_q | ev;
        cnt_d      = cnt_q;
        if (clr) begin
            conflict_d = ev;
            cnt_d      = any_ev ? CNT_W'(1) : '0;
        end else if (any_ev && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Conflict status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
            cnt_q      <= '0;
        end else begin
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Bench for sr_flag_bank: six configurations driven with shared stimulus,
// checked against a cycle model through a scoreboard queue.
module tb_sr_flag_bank;

    localparam int N = 6;
    localparam int MODES [N] = '{0, 1, 2, 3, 0, 0};
    localparam int EDGES [N] = '{0, 0, 0, 0, 1, 0};
    localparam int SYNCS [N] = '{0, 0, 0, 0, 0, 2};

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] qbar;
        logic [7:0] chg;
        logic [7:0] conf;
        logic [2:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] set_v = '0;
    logic [7:0] reset_v = '0;
    logic       clr = 1'b0;

    logic [7:0] q_w    [N];
    logic [7:0] qbar_w [N];
    logic [7:0] chg_w  [N];
    logic [7:0] conf_w [N];
    logic [2:0] cnt_w  [N];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // model state
    logic [7:0] m_q [N], m_chg [N], m_conf [N];
    logic [7:0] m_s1 [N], m_s2 [N], m_r1 [N], m_r2 [N], m_sp [N], m_rp [N];
    logic [2:0] m_cnt [N];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            sr_flag_bank #(
                .CH(8), .MODE(MODES[g]), .SYNC_STAGES(SYNCS[g]),
                .EDGE(EDGES[g]), .CNT_W(3)
            ) dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .set          (set_v),
                .reset        (reset_v),
                .clr          (clr),
                .q            (q_w[g]),
                .qbar         (qbar_w[g]),
                .chg          (chg_w[g]),
                .conflict     (conf_w[g]),
                .conflict_cnt (cnt_w[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_q[i] = '0; m_chg[i] = '0; m_conf[i] = '0; m_cnt[i] = '0;
            m_s1[i] = '0; m_s2[i] = '0; m_r1[i] = '0; m_r2[i] = '0;
            m_sp[i] = '0; m_rp[i] = '0;
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [7:0] sq, rq, se, re, nq, ev;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            sq = (SYNCS[i] == 2) ? m_s2[i] : set_v;
            rq = (SYNCS[i] == 2) ? m_r2[i] : reset_v;
            se = EDGES[i] ? (sq & ~m_sp[i]) : sq;
            re = EDGES[i] ? (rq & ~m_rp[i]) : rq;
            for (int b = 0; b < 8; b++) begin
                if (se[b] && !re[b])      nq[b] = 1'b1;
                else if (!se[b] && re[b]) nq[b] = 1'b0;
                else if (se[b] && re[b]) begin
                    case (MODES[i])
                        0: nq[b] = 1'b0;
                        1: nq[b] = 1'b1;
                        2: nq[b] = ~m_q[i][b];
                        default: nq[b] = m_q[i][b];
                    endcase
                end else nq[b] = m_q[i][b];
            end
            ev = se & re;
            m_s2[i] = m_s1[i]; m_s1[i] = set_v;
            m_r2[i] = m_r1[i]; m_r1[i] = reset_v;
            m_sp[i] = sq; m_rp[i] = rq;
            m_chg[i] = nq ^ m_q[i];
            m_q[i] = nq;
            if (clr) begin
                m_conf[i] = ev;
                m_cnt[i] = (ev != 0) ? 3'd1 : 3'd0;
            end else begin
                m_conf[i] = m_conf[i] | ev;
                if (ev != 0 && m_cnt[i] != 3'd7) m_cnt[i] = m_cnt[i] + 3'd1;
            end
            e.q = m_q[i]; e.qbar = ~m_q[i]; e.chg = m_chg[i];
            e.conf = m_conf[i]; e.cnt = m_cnt[i];
            sb.push_back(e);
        end
    endtask

    // Drive one cycle of stimulus, then compare after the edge. Ends at negedge.
    task automatic cycle(input logic [7:0] s, input logic [7:0] r, input logic c);
        exp_t e;
        set_v = s; reset_v = r; clr = c;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (sb.size() == 0) begin
                chk($sformatf("sb_empty%0d", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("q%0d", i),    32'(q_w[i]),    32'(e.q));
                chk($sformatf("qbar%0d", i), 32'(qbar_w[i]), 32'(e.qbar));
                chk($sformatf("chg%0d", i),  32'(chg_w[i]),  32'(e.chg));
                chk($sformatf("conf%0d", i), 32'(conf_w[i]), 32'(e.conf));
                chk($sformatf("cnt%0d", i),  32'(cnt_w[i]),  32'(e.cnt));
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_q%0d", tag, i),    32'(q_w[i]),    32'h00);
            chk($sformatf("%s_qbar%0d", tag, i), 32'(qbar_w[i]), 32'hFF);
            chk($sformatf("%s_chg%0d", tag, i),  32'(chg_w[i]),  32'h00);
            chk($sformatf("%s_conf%0d", tag, i), 32'(conf_w[i]), 32'h00);
            chk($sformatf("%s_cnt%0d", tag, i),  32'(cnt_w[i]),  32'h0);
        end
    endtask

    initial begin
        model_reset();
        #2;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // basic set / reset
        cycle(8'h05, 8'h00, 1'b0);
        chk("basic_q", 32'(q_w[0]), 32'h05);
        chk("basic_qbar", 32'(qbar_w[0]), 32'hFA);
        chk("basic_chg", 32'(chg_w[0]), 32'h05);
        cycle(8'h00, 8'h00, 1'b0);
        chk("basic_chg_off", 32'(chg_w[0]), 32'h00);
        cycle(8'h00, 8'h01, 1'b0);
        chk("basic_rst", 32'(q_w[0]), 32'h04);

        // both asserted under every policy
        cycle(8'h01, 8'h00, 1'b0);
        cycle(8'h01, 8'h01, 1'b0);
        chk("m0_q0", 32'(q_w[0][0]), 32'd0);
        chk("m1_q0", 32'(q_w[1][0]), 32'd1);
        chk("m2_q0", 32'(q_w[2][0]), 32'd0);
        chk("m3_q0", 32'(q_w[3][0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m%0d_conf0", i), 32'(conf_w[i][0]), 32'd1);
            chk($sformatf("m%0d_cnt", i), 32'(cnt_w[i]), 32'd1);
        end
        cycle(8'h01, 8'h01, 1'b0);
        chk("tog2", 32'(q_w[2][0]), 32'd1);
        cycle(8'h01, 8'h01, 1'b0);
        chk("tog3", 32'(q_w[2][0]), 32'd0);

        // clear, saturation, clear with coincident conflict
        cycle(8'h00, 8'h00, 1'b1);
        chk("clr_cnt", 32'(cnt_w[0]), 32'd0);
        for (int k = 0; k < 10; k++) cycle(8'h03, 8'h03, 1'b0);
        chk("sat_cnt", 32'(cnt_w[0]), 32'd7);
        cycle(8'h00, 8'h00, 1'b1);
        chk("clr2_conf", 32'(conf_w[0]), 32'd0);
        cycle(8'h01, 8'h01, 1'b1);
        chk("clr_coinc_cnt", 32'(cnt_w[0]), 32'd1);
        cycle(8'h00, 8'h00, 1'b1);

        // edge mode: held set does not re-set after a reset edge
        cycle(8'h04, 8'h00, 1'b0);
        chk("edge_set", 32'(q_w[4][2]), 32'd1);
        cycle(8'h04, 8'h04, 1'b0);
        cycle(8'h04, 8'h00, 1'b0);
        cycle(8'h04, 8'h00, 1'b0);
        cycle(8'h04, 8'h00, 1'b0);
        chk("edge_hold", 32'(q_w[4][2]), 32'd0);

        // synchroniser latency
        cycle(8'h08, 8'h00, 1'b0);
        cycle(8'h00, 8'h00, 1'b0);
        chk("lat_early", 32'(q_w[5][3]), 32'd0);
        cycle(8'h00, 8'h00, 1'b0);
        chk("lat_q", 32'(q_w[5][3]), 32'd1);
        chk("lat_chg", 32'(chg_w[5][3]), 32'd1);

        // async reset with a request in flight
        for (int k = 0; k < 3; k++) cycle(8'h00, 8'hFF, 1'b0);
        cycle(8'hFF, 8'h00, 1'b0);
        cycle(8'hFF, 8'h00, 1'b0);
        chk("pre_rst_q", 32'(q_w[0]), 32'hFF);
        set_v = 8'h00; reset_v = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        model_reset();
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle(8'h00, 8'h00, 1'b0);
        chk("lost_req", 32'(q_w[5]), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=%0d expected=%0d", 0, 1);
        $fatal(1);
    end

endmodule
